ps_frame_sequencer: RTL and testbench

Upstream stage of the power-supply trigger serial link. Captures one setpoint request, assembles the fixed 100-bit link frame (sync, address, command, four 20-bit setpoints, nibble checksum), and drives the parallel-to-serial shifter's `load` strobe. It consumes the shifter's `done` level to detect end of frame, then enforces an inter-frame gap. It also reports busy, overrun, timeout and a frame count.

---
 rtl/ps_frame_sequencer.sv | 142 ++++++++++++++
 tb/tb_ps_frame_sequencer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps_frame_sequencer.sv
// ps_frame_sequencer
//
// Upstream stage of the power-supply trigger serial link. It captures one
// setpoint request, builds the 100-bit link frame and strobes the
// parallel-to-serial shifter. The shifter's done level marks the end of the
// frame. An inter-frame gap follows every frame.
//
// Frame layout (LSB goes out on the line first):
//   [7:0] SYNC, [11:8] addr, [15:12] cmd, [35:16] sp0, [55:36] sp1,
//   [75:56] sp2, [95:76] sp3, [99:96] XOR of the 24 nibbles of [95:0]
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   start        request pulse, honoured only in IDLE
//   addr, cmd    4-bit address and command, captured with start
//   sp0..sp3     20-bit setpoints, captured with start
//   clr_err      clears the sticky error flags (a simultaneous set wins)
//   sh_done      shifter end-of-frame level, honoured only in WAIT
//   sh_load      one-cycle load strobe to the shifter
//   frame        frame word to the shifter, held outside LOAD
//   busy         high in LOAD, WAIT and GAP
//   frame_sent   one-cycle pulse per completed frame
//   err_overrun  sticky: start seen while busy
//   err_timeout  sticky: sh_done missing for TIMEOUT cycles in WAIT
//   frame_count  completed frames, wraps at 16 bits
module ps_frame_sequencer #(
    parameter logic [7:0] SYNC       = 8'h7E,
    parameter int         GAP_CYCLES = 4,
    parameter int         TIMEOUT    = 127
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [3:0]    addr,
    input  logic [3:0]    cmd,
    input  logic [19:0]   sp0,
    input  logic [19:0]   sp1,
    input  logic [19:0]   sp2,
    input  logic [19:0]   sp3,
    input  logic          clr_err,
    input  logic          sh_done,
    output logic          sh_load,
    output logic [99:0]   frame,
    output logic          busy,
    output logic          frame_sent,
    output logic          err_overrun,
    output logic          err_timeout,
    output logic [15:0]   frame_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT);
    localparam logic [7:0] GAP_LAST      = 8'(GAP_CYCLES - 1);

    logic [1:0]  state_reg;
    logic [7:0]  wait_cnt_reg;
    logic [7:0]  gap_cnt_reg;

    // Frame body without checksum, straight from the request inputs.
    logic [95:0] body;
    assign body = {sp3, sp2, sp1, sp0, cmd, addr, SYNC};

    // Running XOR over the 24 body nibbles; element 24 is the checksum.
    logic [24:0][3:0] nib_acc;
    assign nib_acc[0] = 4'h0;

    genvar gi;
    generate
        for (gi = 0; gi < 24; gi++) begin : g_checksum
            assign nib_acc[gi + 1] = nib_acc[gi] ^ body[gi*4 +: 4];
        end
    endgenerate

    // Error set conditions. Timeout only fires when sh_done is absent in
    // the very cycle the counter hits the limit: a late done still counts.
    logic overrun_set;
    logic timeout_set;
    assign overrun_set = start && (state_reg != IDLE);
    assign timeout_set = (state_reg == WAIT) && !sh_done
                         && (wait_cnt_reg == TIMEOUT_LIMIT);

    assign sh_load = (state_reg == LOAD);
    assign busy    = (state_reg != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 8'd0;
            gap_cnt_reg  <= 8'd0;
            frame        <= 100'd0;
            frame_sent   <= 1'b0;
            frame_count  <= 16'd0;
            err_overrun  <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            frame_sent  <= 1'b0;
            err_overrun <= overrun_set | (err_overrun & ~clr_err);
            err_timeout <= timeout_set | (err_timeout & ~clr_err);

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        frame     <= {nib_acc[24], body};
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    // sh_done is deliberately not looked at here: the
                    // free-running shifter may still flag the end of an
                    // unrelated frame during the load cycle.
                    wait_cnt_reg <= 8'd0;
                    state_reg    <= WAIT;
                end
                WAIT: begin
                    gap_cnt_reg <= 8'd0;
                    if (sh_done) begin
                        frame_sent  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        state_reg   <= GAP;
                    end else if (wait_cnt_reg == TIMEOUT_LIMIT) begin
                        state_reg <= GAP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps_frame_sequencer.sv
// Directed testbench for ps_frame_sequencer. A behavioural shifter model
// loads on sh_load, puts one bit per cycle on the line LSB-first and holds
// done high while bit 99 is on the line. A manual override drives sh_done
// directly for the timeout and spurious-done scenarios.
module tb_ps_frame_sequencer;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    addr = 4'h0;
    logic [3:0]    cmd = 4'h0;
    logic [19:0]   sp0 = 20'h0;
    logic [19:0]   sp1 = 20'h0;
    logic [19:0]   sp2 = 20'h0;
    logic [19:0]   sp3 = 20'h0;
    logic          clr_err = 1'b0;
    logic          sh_done;
    logic          sh_load;
    logic [99:0]   frame;
    logic          busy;
    logic          frame_sent;
    logic          err_overrun;
    logic          err_timeout;
    logic [15:0]   frame_count;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_count = 16'd0;

    localparam logic [99:0] FRAME_ZERO  = 100'h9_0000000000_0000000000_007E;
    localparam logic [99:0] FRAME_AC    = 100'hB_0000000000_0000000000_137E;
    localparam logic [99:0] FRAME_A5    = 100'hC_0000000000_0000000000_057E;
    localparam logic [99:0] FRAME_SP    = 100'h7_F0F0F_00001_ABCDE_12345_5A7E;

    always #5 clk = ~clk;

    ps_frame_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .addr        (addr),
        .cmd         (cmd),
        .sp0         (sp0),
        .sp1         (sp1),
        .sp2         (sp2),
        .sp3         (sp3),
        .clr_err     (clr_err),
        .sh_done     (sh_done),
        .sh_load     (sh_load),
        .frame       (frame),
        .busy        (busy),
        .frame_sent  (frame_sent),
        .err_overrun (err_overrun),
        .err_timeout (err_timeout),
        .frame_count (frame_count)
    );

    // ---------------- shifter model ----------------
    logic [99:0] mdl_sreg = 100'd0;
    int          mdl_bit = 0;
    logic        mdl_active = 1'b0;
    logic        mdl_done;
    logic        man_sel = 1'b0;
    logic        man_done = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mdl_active <= 1'b0;
            mdl_bit    <= 0;
        end else if (sh_load) begin
            mdl_sreg   <= frame;
            mdl_bit    <= 0;
            mdl_active <= 1'b1;
        end else if (mdl_active) begin
            if (mdl_bit == 99) mdl_active <= 1'b0;
            else               mdl_bit <= mdl_bit + 1;
        end
    end

    assign mdl_done = mdl_active && (mdl_bit == 99);
    assign sh_done  = man_sel ? man_done : mdl_done;

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          load_cnt = 0;
    int          load_cyc = -1;
    int          sent_cnt = 0;
    int          sent_hist [16];
    int          rx_cnt = 0;
    logic [99:0] rx_hist [16];
    logic [99:0] rx_buf = 100'd0;
    logic [99:0] load_frame = 100'd0;
    int          idle_cyc = -1;
    int          to_cyc = -1;
    bit          prev_busy = 1'b0;
    bit          prev_to = 1'b0;
    bit          frame_moved = 1'b0;

    always @(negedge clk) begin
        if (sh_load) begin
            load_cnt   = load_cnt + 1;
            load_cyc   = cyc;
            load_frame = frame;
        end else if (busy && frame !== load_frame) begin
            frame_moved = 1'b1;
        end
        if (frame_sent) begin
            sent_hist[sent_cnt % 16] = cyc;
            sent_cnt = sent_cnt + 1;
        end
        if (prev_busy && !busy) idle_cyc = cyc;
        prev_busy = busy;
        if (!prev_to && err_timeout) to_cyc = cyc;
        prev_to = err_timeout;
        if (mdl_active) begin
            rx_buf[mdl_bit] = mdl_sreg[mdl_bit];
            if (mdl_bit == 99) begin
                rx_hist[rx_cnt % 16] = rx_buf;
                rx_cnt = rx_cnt + 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_start(input logic [3:0] a, input logic [3:0] c,
                            input logic [19:0] s0, input logic [19:0] s1,
                            input logic [19:0] s2, input logic [19:0] s3,
                            output int n);
        @(posedge clk); #1;
        addr = a; cmd = c; sp0 = s0; sp1 = s1; sp2 = s2; sp3 = s3;
        start = 1'b1;
        n = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int n);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (!busy && idle_cyc > n) break;
        end
    endtask

    task automatic pulse_clr;
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        @(negedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        vectors++;
        if ({sh_load, busy, frame_sent, err_overrun, err_timeout} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b need 00000",
                     {sh_load, busy, frame_sent, err_overrun, err_timeout});
        end
        vectors++;
        if (frame !== 100'd0 || frame_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_data: frame=%h count=%0d need 0/0", frame, frame_count);
        end
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_default;
        int n, bl, bs, br;
        bl = load_cnt; bs = sent_cnt; br = rx_cnt;
        do_start(4'h0, 4'h0, 20'h0, 20'h0, 20'h0, 20'h0, n);
        wait_idle(n);
        exp_count = exp_count + 16'd1;
        vectors++;
        if (frame !== FRAME_ZERO) begin
            miscompares++; $display("FAIL default_frame: got %h need %h", frame, FRAME_ZERO);
        end
        vectors++;
        if (load_cnt - bl !== 1 || load_cyc !== n + 1) begin
            miscompares++;
            $display("FAIL default_load: loads=%0d at %0d need 1 at %0d", load_cnt - bl, load_cyc, n + 1);
        end
        vectors++;
        if (sent_cnt - bs !== 1 || sent_hist[bs % 16] !== n + 102) begin
            miscompares++;
            $display("FAIL default_sent: pulses=%0d at %0d need 1 at %0d", sent_cnt - bs, sent_hist[bs % 16], n + 102);
        end
        vectors++;
        if (idle_cyc !== n + 106) begin
            miscompares++; $display("FAIL default_idle: got %0d need %0d", idle_cyc, n + 106);
        end
        vectors++;
        if (rx_cnt - br !== 1 || rx_hist[br % 16] !== FRAME_ZERO) begin
            miscompares++;
            $display("FAIL default_serial: got %h need %h", rx_hist[br % 16], FRAME_ZERO);
        end
        vectors++;
        if (frame_count !== exp_count || err_overrun !== 1'b0 || err_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL default_status: count=%0d ovr=%b to=%b need %0d/0/0",
                     frame_count, err_overrun, err_timeout, exp_count);
        end
    endtask

    task automatic test_addr_cmd;
        int n, br;
        br = rx_cnt;
        do_start(4'h3, 4'h1, 20'h0, 20'h0, 20'h0, 20'h0, n);
        wait_idle(n);
        exp_count = exp_count + 16'd1;
        vectors++;
        if (frame !== FRAME_AC) begin
            miscompares++; $display("FAIL addr_cmd_frame: got %h need %h", frame, FRAME_AC);
        end
        vectors++;
        if (rx_hist[br % 16] !== FRAME_AC || frame_count !== exp_count) begin
            miscompares++;
            $display("FAIL addr_cmd_serial: got %h count=%0d need %h count=%0d",
                     rx_hist[br % 16], frame_count, FRAME_AC, exp_count);
        end
    endtask

    task automatic test_setpoints;
        int n, br;
        br = rx_cnt;
        do_start(4'hA, 4'h5, 20'h12345, 20'hABCDE, 20'h00001, 20'hF0F0F, n);
        wait_idle(n);
        exp_count = exp_count + 16'd1;
        vectors++;
        if (frame !== FRAME_SP || rx_hist[br % 16] !== FRAME_SP) begin
            miscompares++;
            $display("FAIL setpoint_frame: got %h serial %h need %h", frame, rx_hist[br % 16], FRAME_SP);
        end
    endtask

    task automatic test_back_to_back;
        int n, bl, bs, br;
        bl = load_cnt; bs = sent_cnt; br = rx_cnt;
        @(posedge clk); #1;
        addr = 4'h0; cmd = 4'h0; sp0 = 20'h0; sp1 = 20'h0; sp2 = 20'h0; sp3 = 20'h0;
        start = 1'b1;
        n = cyc;
        for (int i = 0; i < 20 && load_cnt - bl < 1; i++) @(negedge clk);
        @(posedge clk); #1 addr = 4'h5;
        for (int i = 0; i < 400 && load_cnt - bl < 3; i++) @(negedge clk);
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 400 && sent_cnt - bs < 3; i++) @(negedge clk);
        wait_idle(cyc);
        exp_count = exp_count + 16'd3;
        vectors++;
        if (sent_cnt - bs !== 3) begin
            miscompares++; $display("FAIL b2b_frames: got %0d need 3", sent_cnt - bs);
        end
        vectors++;
        if (sent_hist[(bs + 1) % 16] - sent_hist[bs % 16] !== 106 ||
            sent_hist[(bs + 2) % 16] - sent_hist[(bs + 1) % 16] !== 106) begin
            miscompares++;
            $display("FAIL b2b_period: got %0d,%0d need 106,106",
                     sent_hist[(bs + 1) % 16] - sent_hist[bs % 16],
                     sent_hist[(bs + 2) % 16] - sent_hist[(bs + 1) % 16]);
        end
        vectors++;
        if (sent_hist[bs % 16] !== n + 102) begin
            miscompares++; $display("FAIL b2b_first: got %0d need %0d", sent_hist[bs % 16], n + 102);
        end
        vectors++;
        if (rx_hist[br % 16] !== FRAME_ZERO || rx_hist[(br + 1) % 16] !== FRAME_A5) begin
            miscompares++;
            $display("FAIL b2b_data: got %h,%h need %h,%h",
                     rx_hist[br % 16], rx_hist[(br + 1) % 16], FRAME_ZERO, FRAME_A5);
        end
        vectors++;
        if (frame_moved !== 1'b0) begin
            miscompares++; $display("FAIL b2b_frame_stable: frame changed while busy");
        end
        vectors++;
        if (err_overrun !== 1'b1 || frame_count !== exp_count) begin
            miscompares++;
            $display("FAIL b2b_status: ovr=%b count=%0d need 1/%0d", err_overrun, frame_count, exp_count);
        end
        pulse_clr();
        vectors++;
        if (err_overrun !== 1'b0) begin
            miscompares++; $display("FAIL b2b_clr: ovr=%b need 0", err_overrun);
        end
    endtask

    task automatic test_timeout;
        int n, bs;
        bs = sent_cnt;
        man_sel = 1'b1; man_done = 1'b0;
        do_start(4'h1, 4'h2, 20'h0, 20'h0, 20'h0, 20'h0, n);
        wait_idle(n);
        vectors++;
        if (err_timeout !== 1'b1 || to_cyc < n + 120 || to_cyc > n + 140) begin
            miscompares++;
            $display("FAIL timeout_flag: flag=%b at %0d need 1 near %0d", err_timeout, to_cyc, n + 130);
        end
        vectors++;
        if (idle_cyc !== to_cyc + 4) begin
            miscompares++; $display("FAIL timeout_gap: idle at %0d need %0d", idle_cyc, to_cyc + 4);
        end
        vectors++;
        if (sent_cnt !== bs || frame_count !== exp_count || err_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_nocount: pulses=%0d count=%0d ovr=%b need 0/%0d/0",
                     sent_cnt - bs, frame_count, err_overrun, exp_count);
        end
        pulse_clr();
        vectors++;
        if (err_timeout !== 1'b0) begin
            miscompares++; $display("FAIL timeout_clr: flag=%b need 0", err_timeout);
        end
        man_sel = 1'b0;
    endtask

    task automatic test_spurious_done;
        int n, p, bs;
        bs = sent_cnt;
        man_sel = 1'b1; man_done = 1'b1;
        repeat (6) @(posedge clk);
        do_start(4'h0, 4'h0, 20'h0, 20'h0, 20'h0, 20'h0, n);
        // still in the LOAD cycle with done high; drop it in WAIT
        @(posedge clk); #1 man_done = 1'b0;
        repeat (10) @(posedge clk);
        // start and clr_err together while busy: the set must win
        #1 start = 1'b1; clr_err = 1'b1;
        @(posedge clk); #1 start = 1'b0; clr_err = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk); #1;
        vectors++;
        if (sent_cnt !== bs || frame_count !== exp_count || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL spurious_ignored: pulses=%0d count=%0d busy=%b need 0/%0d/1",
                     sent_cnt - bs, frame_count, busy, exp_count);
        end
        vectors++;
        if (err_overrun !== 1'b1) begin
            miscompares++; $display("FAIL clr_vs_set: ovr=%b need 1", err_overrun);
        end
        @(posedge clk); #1 man_done = 1'b1;
        p = cyc;
        @(posedge clk); #1 man_done = 1'b0;
        wait_idle(p);
        exp_count = exp_count + 16'd1;
        vectors++;
        if (sent_cnt - bs !== 1 || sent_hist[bs % 16] !== p + 1 || idle_cyc !== p + 5) begin
            miscompares++;
            $display("FAIL spurious_real_done: pulses=%0d at %0d idle %0d need 1 at %0d idle %0d",
                     sent_cnt - bs, sent_hist[bs % 16], idle_cyc, p + 1, p + 5);
        end
        vectors++;
        if (frame_count !== exp_count || err_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL spurious_count: count=%0d to=%b need %0d/0", frame_count, err_timeout, exp_count);
        end
        pulse_clr();
        man_sel = 1'b0;
    endtask

    task automatic test_reset_mid;
        int n, br;
        do_start(4'hA, 4'h5, 20'h12345, 20'hABCDE, 20'h00001, 20'hF0F0F, n);
        repeat (48) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        vectors++;
        if ({sh_load, busy, frame_sent, err_overrun, err_timeout} !== 5'b0 ||
            frame !== 100'd0 || frame_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_mid: flags=%b frame=%h count=%0d need all 0",
                     {sh_load, busy, frame_sent, err_overrun, err_timeout}, frame, frame_count);
        end
        @(posedge clk); #1 reset = 1'b0;
        exp_count = 16'd0;
        repeat (2) @(posedge clk);
        br = rx_cnt;
        do_start(4'hA, 4'h5, 20'h12345, 20'hABCDE, 20'h00001, 20'hF0F0F, n);
        wait_idle(n);
        exp_count = exp_count + 16'd1;
        vectors++;
        if (frame !== FRAME_SP || rx_hist[br % 16] !== FRAME_SP || frame_count !== exp_count) begin
            miscompares++;
            $display("FAIL reset_recover: frame=%h serial=%h count=%0d need %h count=%0d",
                     frame, rx_hist[br % 16], frame_count, FRAME_SP, exp_count);
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_addr_cmd();
        test_setpoints();
        test_back_to_back();
        test_timeout();
        test_spurious_done();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
